des_round_controller: RTL and testbench

//  Sequencing FSM for the iterative DES core. Accepts one 64-bit block per transaction (valid/ready).

---
 rtl/des_round_controller.sv | 114 +++++++++++
 tb/tb_des_round_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_controller.sv
// Sequencing FSM for the iterative DES core: load, NUM_ROUNDS Feistel rounds with
// key-schedule rotate controls, final swap/FP capture, then hold until the consumer takes the result.
module des_round_controller #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_decrypt,
  input  logic       abort,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       dp_load,
  output logic       dp_round,
  output logic [3:0] round_idx,
  output logic [1:0] ks_shift,
  output logic       ks_dir,
  output logic       dp_final,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mode, mode_nxt;

  // Rounds 1, 2, 9 and 16 rotate by one; decryption starts from C16/D16 == C0/D0, so round 1 skips.
  function automatic logic [1:0] shift_sched(input logic dec, input logic [3:0] idx);
    logic single;
    single = (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    if (dec && (idx == 4'd0)) return 2'd0;
    return single ? 2'd1 : 2'd2;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_load   = 1'b0;
    dp_round  = 1'b0;
    dp_final  = 1'b0;
    round_idx = 4'd0;
    ks_shift  = 2'd0;
    ks_dir    = 1'b0;
    busy      = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mode_nxt  = in_decrypt;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        dp_load   = 1'b1;
        cnt_nxt   = 4'd0;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        dp_round  = 1'b1;
        round_idx = cnt;
        ks_dir    = mode;
        ks_shift  = shift_sched(mode, cnt);
        if (cnt == LAST_ROUND) begin
          cnt_nxt   = 4'd0;
          state_nxt = S_FINAL;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_FINAL: begin
        dp_final  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over both the counter advance and the output handshake.
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 4'd0;
    end
  end

endmodule

// File: tb/tb_des_round_controller.sv
// Bench for des_round_controller: a 16-round and a 1-round build share one stimulus stream and are
// checked every cycle against a transaction-position model, plus directed schedule/latency cases.
module tb_des_round_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_decrypt = 1'b0, abort = 1'b0, out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_dp_load, a_dp_round, a_ks_dir, a_dp_final, a_busy;
  logic [3:0] a_round_idx;
  logic [1:0] a_ks_shift;
  logic       b_in_ready, b_out_valid, b_dp_load, b_dp_round, b_ks_dir, b_dp_final, b_busy;
  logic [3:0] b_round_idx;
  logic [1:0] b_ks_shift;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_round_controller #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_decrypt(in_decrypt), .abort(abort), .out_valid(a_out_valid), .out_ready(out_ready),
    .dp_load(a_dp_load), .dp_round(a_dp_round), .round_idx(a_round_idx), .ks_shift(a_ks_shift),
    .ks_dir(a_ks_dir), .dp_final(a_dp_final), .busy(a_busy)
  );

  des_round_controller #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_decrypt(in_decrypt), .abort(abort), .out_valid(b_out_valid), .out_ready(out_ready),
    .dp_load(b_dp_load), .dp_round(b_dp_round), .round_idx(b_round_idx), .ks_shift(b_ks_shift),
    .ks_dir(b_ks_dir), .dp_final(b_dp_final), .busy(b_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pos = -1 idle, otherwise cycles since the accept edge (0 load, 1..N rounds, N+1 final, N+2 done).
  int   pos[2] = '{-1, -1};
  logic mdl_mode[2] = '{1'b0, 1'b0};
  int   nrounds[2] = '{16, 1};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) pos[i] <= -1;
      else if (pos[i] == -1) begin
        if (in_valid) begin
          pos[i]      <= 0;
          mdl_mode[i] <= in_decrypt;
        end
      end else if (abort) pos[i] <= -1;
      else if (pos[i] == nrounds[i] + 2) begin
        if (out_ready) pos[i] <= -1;
      end else pos[i] <= pos[i] + 1;
    end
  end

  function automatic int exp_shift(input logic dec, input int r);
    if (dec && r == 1) return 0;
    if (r == 1 || r == 2 || r == 9 || r == 16) return 1;
    return 2;
  endfunction

  task automatic cmp_dut(input int i, input string tag, input logic rdy, input logic bsy,
                         input logic ld, input logic rnd, input logic fin, input logic ov,
                         input logic dir, input logic [3:0] idx, input logic [1:0] sh);
    int  p;
    int  n;
    bit  in_round;
    p = pos[i];
    n = nrounds[i];
    in_round = (p >= 1) && (p <= n);
    chk({tag, ".in_ready"}, int'(rdy), int'(p == -1));
    chk({tag, ".busy"}, int'(bsy), int'(p != -1));
    chk({tag, ".dp_load"}, int'(ld), int'(p == 0));
    chk({tag, ".dp_round"}, int'(rnd), int'(in_round));
    chk({tag, ".dp_final"}, int'(fin), int'(p == n + 1));
    chk({tag, ".out_valid"}, int'(ov), int'(p == n + 2));
    chk({tag, ".round_idx"}, int'(idx), in_round ? p - 1 : 0);
    chk({tag, ".ks_dir"}, int'(dir), in_round ? int'(mdl_mode[i]) : 0);
    chk({tag, ".ks_shift"}, int'(sh), in_round ? exp_shift(mdl_mode[i], p) : 0);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, "n16", a_in_ready, a_busy, a_dp_load, a_dp_round, a_dp_final, a_out_valid,
            a_ks_dir, a_round_idx, a_ks_shift);
    cmp_dut(1, "n1", b_in_ready, b_busy, b_dp_load, b_dp_round, b_dp_final, b_out_valid,
            b_ks_dir, b_round_idx, b_ks_shift);
  end

  // Present a block while idle and return just after the accept edge.
  task automatic start_block(input logic dec, input logic ordy);
    @(negedge clk);
    in_valid   = 1'b1;
    in_decrypt = dec;
    out_ready  = ordy;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_decrypt = ~dec;
  endtask

  task automatic wait_round(input int idx, input string name);
    int n;
    n = 0;
    while (!(a_dp_round && a_round_idx == 4'(idx)) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk({name, ".timeout"}, 0, 1);
  endtask

  task automatic run_schedule(input logic dec, input int exp_seq[16], input string name);
    int seq[$];
    int lat16, lat1, total, rounds1, shift1;
    lat16 = -1; lat1 = -1; total = 0; rounds1 = 0; shift1 = -1;
    start_block(dec, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (a_dp_round) begin
        seq.push_back(int'(a_ks_shift));
        total += int'(a_ks_shift);
        chk({name, ".ks_dir"}, int'(a_ks_dir), int'(dec));
      end
      if (b_dp_round) begin
        rounds1++;
        shift1 = int'(b_ks_shift);
      end
      if (a_out_valid && lat16 < 0) lat16 = c;
      if (b_out_valid && lat1 < 0) lat1 = c;
    end
    chk({name, ".rounds"}, seq.size(), 16);
    for (int k = 0; k < 16 && k < seq.size(); k++) chk({name, ".ks_shift_seq"}, seq[k], exp_seq[k]);
    chk({name, ".latency16"}, lat16, 18);
    chk({name, ".latency1"}, lat1, 3);
    chk({name, ".n1_rounds"}, rounds1, 1);
    chk({name, ".n1_shift"}, shift1, dec ? 0 : 1);
    if (!dec) chk({name, ".rotate_total"}, total, 28);
  endtask

  initial begin
    int enc_seq[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_seq[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int n;

    repeat (2) @(negedge clk);
    chk("reset.in_ready", int'(a_in_ready), 1);
    chk("reset.busy", int'(a_busy), 0);
    rst_n = 1'b1;

    run_schedule(1'b0, enc_seq, "enc");
    run_schedule(1'b1, dec_seq, "dec");

    // Consumer stalls in DONE.
    start_block(1'b0, 1'b0);
    n = 0;
    while (!a_out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("stall.reach_done", int'(a_out_valid), 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("stall.out_valid", int'(a_out_valid), 1);
      chk("stall.in_ready", int'(a_in_ready), 0);
      chk("stall.strobes", int'({a_dp_load, a_dp_round, a_dp_final}), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall.release_idle", int'(a_in_ready), 1);
    chk("stall.release_ov", int'(a_out_valid), 0);

    // Abort mid-ROUND, then a clean block from round 0.
    start_block(1'b0, 1'b1);
    wait_round(7, "abort");
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort.idle", int'(a_in_ready), 1);
    chk("abort.no_final", int'(a_dp_final), 0);
    start_block(1'b0, 1'b1);
    n = 0;
    @(posedge clk); #1;
    chk("abort.first_idx", int'(a_round_idx), 0);
    while (a_dp_round && n < 40) begin n++; @(posedge clk); #1; end
    chk("abort.next_rounds", n, 16);
    repeat (4) @(posedge clk);

    // Asynchronous reset in the middle of the round sequence.
    start_block(1'b1, 1'b1);
    wait_round(5, "rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.in_ready", int'(a_in_ready), 1);
    chk("rst.others", int'({a_out_valid, a_dp_load, a_dp_round, a_round_idx, a_ks_shift,
                            a_ks_dir, a_dp_final, a_busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.idle_after", int'(a_busy), 0);

    // Random traffic, checked every cycle by the model comparison.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(0, 1) == 1);
      in_decrypt = $urandom_range(0, 1) == 1;
      abort      = ($urandom_range(0, 23) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
